// File: rtl/rotate_batch_controller.sv
// -----------------------------------------------------------------------------
// rotate_batch_controller
//
// Purpose:
//   Sequences the rotate (rho) datapath over a batch of NUM_FILES test vectors.
//   For each vector k it pulses the file reader, waits one dead cycle for the
//   reader's data to settle, starts the rotate core, waits for its completion
//   (bounded by TIMEOUT cycles), then pulses the result writer. After the last
//   vector, or after a timeout, it pulses done and returns to IDLE.
//
// Parameters:
//   NUM_FILES  vectors per batch, 1..1024
//   TIMEOUT    maximum cycles spent in WAIT before the batch is aborted, >= 2
//
// Ports:
//   clk         in   1   single clock, all logic on posedge
//   rst         in   1   synchronous, active-high reset
//   start       in   1   request to run a batch, honoured only in IDLE
//   rot_done    in   1   rotate core finished, honoured only in WAIT
//   read_file   out  1   one-cycle pulse to the file reader
//   file_index  out  10  current vector index (reader and writer)
//   rot_start   out  1   one-cycle pulse that starts the rotate core
//   write_file  out  1   one-cycle pulse to the result writer
//   busy        out  1   high in every state except IDLE
//   done        out  1   one-cycle pulse at batch end
//   error       out  1   sticky timeout flag, cleared by start or rst
// -----------------------------------------------------------------------------
module rotate_batch_controller #(
    parameter int NUM_FILES = 10,
    parameter int TIMEOUT   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rot_done,
    output logic       read_file,
    output logic [9:0] file_index,
    output logic       rot_start,
    output logic       write_file,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [9:0]       LAST_IDX  = 10'(NUM_FILES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ROT   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WRITE = 3'd5,
        ST_NEXT  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Control pulse bundle: {read_file, rot_start, write_file, busy, done}.
    // Decoding the *next* state and registering the result gives outputs that
    // are glitch-free yet line up exactly with the registered state.
    function automatic logic [4:0] decode_outputs(input state_t st);
        logic [4:0] o;
        o = 5'b00000;
        case (st)
            ST_IDLE:  o = 5'b00000;
            ST_READ:  o = 5'b10010;
            ST_LOAD:  o = 5'b00010;
            ST_ROT:   o = 5'b01010;
            ST_WAIT:  o = 5'b00010;
            ST_WRITE: o = 5'b00110;
            ST_NEXT:  o = 5'b00010;
            ST_DONE:  o = 5'b00011;
            default:  o = 5'b00000;
        endcase
        return o;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_s;
    logic [9:0]       index_r;
    logic [9:0]       index_s;
    logic             error_r;
    logic             error_s;
    logic [4:0]       pulses_r;
    logic [4:0]       pulses_s;

    // Next-state, index, wait counter and sticky error computation.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        index_s    = index_r;
        error_s    = error_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_READ;
                    index_s = 10'd0;
                    error_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                // Dead cycle: lets the reader's wide data settle before the core starts.
                state_s = ST_ROT;
            end
            ST_ROT: begin
                // rot_done is deliberately not looked at here.
                state_s    = ST_WAIT;
                wait_cnt_s = {CNT_W{1'b0}};
            end
            ST_WAIT: begin
                // rot_done takes priority over a simultaneous timeout.
                if (rot_done) begin
                    state_s = ST_WRITE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s = ST_DONE;
                    error_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WRITE: begin
                state_s = ST_NEXT;
            end
            ST_NEXT: begin
                if (index_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    index_s = index_r + 10'd1;
                    state_s = ST_READ;
                end
            end
            ST_DONE: begin
                // file_index is left untouched until the next start.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        pulses_s = decode_outputs(state_s);
    end

    // State, counters, sticky error and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
            index_r    <= 10'd0;
            error_r    <= 1'b0;
            pulses_r   <= 5'b00000;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            index_r    <= index_s;
            error_r    <= error_s;
            pulses_r   <= pulses_s;
        end
    end

    assign read_file  = pulses_r[4];
    assign rot_start  = pulses_r[3];
    assign write_file = pulses_r[2];
    assign busy       = pulses_r[1];
    assign done       = pulses_r[0];
    assign file_index = index_r;
    assign error      = error_r;

endmodule

// File: tb/tb_rotate_batch_controller.sv
// -----------------------------------------------------------------------------
// tb_rotate_batch_controller
//
// Directed, table-driven bench. Instance A (NUM_FILES=3, TIMEOUT=8) is driven
// from a per-cycle table of {inputs, expected outputs}; instance B
// (NUM_FILES=1) is exercised by a short hand-written sequence.
// Expected output word: {read_file, rot_start, write_file, busy, done, error,
// file_index[9:0]}.
// -----------------------------------------------------------------------------
module tb_rotate_batch_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic       rst_a = 1'b0, start_a = 1'b0, rd_a = 1'b0;
    logic       read_a, rot_a, write_a, busy_a, done_a, err_a;
    logic [9:0] idx_a;

    // Instance B signals
    logic       rst_b = 1'b0, start_b = 1'b0, rd_b = 1'b0;
    logic       read_b, rot_b, write_b, busy_b, done_b, err_b;
    logic [9:0] idx_b;

    rotate_batch_controller #(.NUM_FILES(3), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .rot_done(rd_a),
        .read_file(read_a), .file_index(idx_a), .rot_start(rot_a),
        .write_file(write_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    rotate_batch_controller #(.NUM_FILES(1), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .rot_done(rd_b),
        .read_file(read_b), .file_index(idx_b), .rot_start(rot_b),
        .write_file(write_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        rd;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic r, input logic s, input logic d,
                        input logic er, input logic erot, input logic ew,
                        input logic eb, input logic ed, input logic ee,
                        input logic [9:0] ix);
        vec_t v;
        v.rst   = r;
        v.start = s;
        v.rd    = d;
        v.exp   = {er, erot, ew, eb, ed, ee, ix};
        tbl.push_back(v);
    endtask

    // Record whose next state is READ (inputs are those of the previous cycle).
    task automatic to_read(input logic [9:0] k, input logic s, input logic d, input logic ee);
        push(1'b0, s, d, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ee, k);
    endtask

    // LOAD, ROT, WAIT x(n+1), WRITE, NEXT for vector k; h = rot_done level
    // outside the WAIT cycles, st = start level during READ.
    task automatic vec_body(input logic [9:0] k, input int n, input logic h,
                            input logic st, input logic ee);
        push(1'b0, st,   h,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ee, k); // LOAD
        push(1'b0, 1'b0, h,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ee, k); // ROT
        push(1'b0, 1'b0, h,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ee, k); // WAIT entry
        for (int j = 0; j < n; j++)
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ee, k); // WAIT
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ee, k); // WRITE
        push(1'b0, 1'b0, h,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ee, k); // NEXT
    endtask

    task automatic to_done(input logic [9:0] k, input logic d, input logic ee);
        push(1'b0, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ee, k);
    endtask

    task automatic to_idle(input logic [9:0] k, input logic d, input logic ee);
        push(1'b0, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ee, k);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int reads, rots, writes, dones, idx_nz, done_cyc;

        // ---- 1: reset, three vectors with rot_done 2 cycles into WAIT ----
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        to_read(10'd0, 1'b1, 1'b0, 1'b0);
        vec_body(10'd0, 2, 1'b0, 1'b0, 1'b0);
        to_read(10'd1, 1'b0, 1'b0, 1'b0);
        vec_body(10'd1, 2, 1'b0, 1'b0, 1'b0);
        to_read(10'd2, 1'b0, 1'b0, 1'b0);
        vec_body(10'd2, 2, 1'b0, 1'b0, 1'b0);
        to_done(10'd2, 1'b0, 1'b0);                  // 25th edge after start
        to_idle(10'd2, 1'b1, 1'b0);                  // rot_done ignored in IDLE
        to_idle(10'd2, 1'b1, 1'b0);

        // ---- 2: rot_done held high, 6 cycles per vector ----
        to_read(10'd0, 1'b1, 1'b1, 1'b0);
        vec_body(10'd0, 0, 1'b1, 1'b0, 1'b0);
        to_read(10'd1, 1'b0, 1'b1, 1'b0);
        vec_body(10'd1, 0, 1'b1, 1'b0, 1'b0);
        to_read(10'd2, 1'b0, 1'b1, 1'b0);
        vec_body(10'd2, 0, 1'b1, 1'b0, 1'b0);
        to_done(10'd2, 1'b1, 1'b0);
        to_idle(10'd2, 1'b0, 1'b0);

        // ---- 3: timeout after 8 WAIT cycles ----
        to_read(10'd0, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0); // LOAD
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0); // ROT
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0); // WAIT cnt0
        for (int j = 0; j < 7; j++)
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
        to_done(10'd0, 1'b0, 1'b1);                  // error raised with done
        to_idle(10'd0, 1'b0, 1'b1);                  // busy falls, error sticky
        to_idle(10'd0, 1'b0, 1'b1);

        // ---- 4: new start clears error; rot_done on the last timeout cycle;
        //         start while busy is ignored ----
        to_read(10'd0, 1'b1, 1'b0, 1'b0);
        vec_body(10'd0, 7, 1'b0, 1'b0, 1'b0);        // rot_done at counter==7
        to_read(10'd1, 1'b0, 1'b0, 1'b0);
        vec_body(10'd1, 2, 1'b0, 1'b1, 1'b0);        // start during READ idx 1
        to_read(10'd2, 1'b0, 1'b0, 1'b0);
        vec_body(10'd2, 1, 1'b0, 1'b0, 1'b0);
        to_done(10'd2, 1'b0, 1'b0);
        to_idle(10'd2, 1'b0, 1'b0);

        // ---- 5: rst during WAIT of index 2 ----
        to_read(10'd0, 1'b1, 1'b0, 1'b0);            // index returns to 0
        vec_body(10'd0, 1, 1'b0, 1'b0, 1'b0);
        to_read(10'd1, 1'b0, 1'b0, 1'b0);
        vec_body(10'd1, 1, 1'b0, 1'b0, 1'b0);
        to_read(10'd2, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2); // LOAD
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2); // ROT
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2); // WAIT
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2); // WAIT
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0); // rst
        to_idle(10'd0, 1'b0, 1'b0);

        // Apply table to instance A
        foreach (tbl[i]) begin
            @(negedge clk);
            rst_a   = tbl[i].rst;
            start_a = tbl[i].start;
            rd_a    = tbl[i].rd;
            @(posedge clk);
            #1;
            checks++;
            if ({read_a, rot_a, write_a, busy_a, done_a, err_a, idx_a} !== tbl[i].exp) begin
                errors++;
                $display("FAIL vec%0d {rd,rot,wr,busy,done,err,idx}: got %h expected %h",
                         i, {read_a, rot_a, write_a, busy_a, done_a, err_a, idx_a}, tbl[i].exp);
            end
        end
        @(negedge clk);
        rst_a = 1'b0; start_a = 1'b0; rd_a = 1'b0;

        // ---- 6: NUM_FILES=1 on instance B, rot_done held high ----
        rst_b = 1'b1;
        @(negedge clk);
        rst_b   = 1'b0;
        start_b = 1'b1;
        rd_b    = 1'b1;
        reads = 0; rots = 0; writes = 0; dones = 0; idx_nz = 0; done_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            if (read_b)  reads++;
            if (rot_b)   rots++;
            if (write_b) writes++;
            if (done_b) begin
                dones++;
                done_cyc = c;
            end
            if (idx_b != 10'd0) idx_nz++;
        end
        check("nf1_read_pulses",  reads,    1);
        check("nf1_rot_pulses",   rots,     1);
        check("nf1_write_pulses", writes,   1);
        check("nf1_done_pulses",  dones,    1);
        check("nf1_done_latency", done_cyc, 7);
        check("nf1_index_nonzero_cycles", idx_nz, 0);
        check("nf1_busy_end",     int'(busy_b), 0);
        check("nf1_error_end",    int'(err_b),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
